// File: rtl/mem_pkg.sv
// mem_pkg: shared sizes, fault bit positions, FSM states and port selector for the memory arbiter
package mem_pkg;
    localparam logic [1:0] MEM_OP_SIZE_BYTE      = 2'b00;
    localparam logic [1:0] MEM_OP_SIZE_HALF_WORD = 2'b01;
    localparam logic [1:0] MEM_OP_SIZE_WORD      = 2'b10;
    localparam int FAULT_OP     = 2;
    localparam int FAULT_ADDR   = 1;
    localparam int FAULT_ACCESS = 0;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    typedef enum logic {PORT_INSTR = 1'b0, PORT_DATA = 1'b1} port_sel_e;
    function automatic logic [2:0] fault_vec(input logic op, input logic addr, input logic access_n);
        logic [2:0] f;
        f[FAULT_OP]     = op;
        f[FAULT_ADDR]   = addr;
        f[FAULT_ACCESS] = ~access_n;
        return f;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction port, data port and memory-side bus of the arbiter
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_rsp_valid;
    logic [31:0] i_rdata;
    logic [2:0]  i_fault;
    logic        d_req;
    logic        d_is_write;
    logic        d_is_unsigned;
    logic [1:0]  d_op_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic [2:0]  d_fault;
    logic        mem_enable_n;
    logic        mem_is_write;
    logic        mem_is_unsigned;
    logic [1:0]  mem_op_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
    logic        mem_op_fault;
    logic        mem_addr_fault;
    logic        mem_access_fault_n;
    modport slave (
        input  i_req, i_addr, d_req, d_is_write, d_is_unsigned, d_op_size, d_addr, d_wdata,
               mem_out, mem_op_fault, mem_addr_fault, mem_access_fault_n,
        output i_ready, i_rsp_valid, i_rdata, i_fault, d_ready, d_rsp_valid, d_rdata, d_fault,
               mem_enable_n, mem_is_write, mem_is_unsigned, mem_op_size, mem_addr, mem_in
    );
    modport master (
        output i_req, i_addr, d_req, d_is_write, d_is_unsigned, d_op_size, d_addr, d_wdata,
               mem_out, mem_op_fault, mem_addr_fault, mem_access_fault_n,
        input  i_ready, i_rsp_valid, i_rdata, i_fault, d_ready, d_rsp_valid, d_rdata, d_fault,
               mem_enable_n, mem_is_write, mem_is_unsigned, mem_op_size, mem_addr, mem_in
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant whose history only advances on an accepted request
module rr_arbiter2 import mem_pkg::*; #(
    parameter logic RST_PRIO = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output port_sel_e  grant
);
    port_sel_e last;
    // contention goes to the port not served last; a lone requester always wins
    always_comb grant = (req == 2'b11) ? port_sel_e'(~last) : (req[1] ? PORT_DATA : PORT_INSTR);
    // remember who was served; reset points away from the favoured port so it wins first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last <= port_sel_e'(~RST_PRIO);
        else if (accept) last <= grant;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between instruction and data ports, one access per two cycles
module mem_arbiter import mem_pkg::*; #(
    parameter logic RST_PRIO = 1'b1
) (
    input logic        clk,
    input logic        reset_n,
    mem_arbiter_if.slave bus
);
    state_e      state, state_next;
    port_sel_e   grant, owner;
    logic        accept;
    logic [2:0]  fault;
    logic [31:0] rdata;

    rr_arbiter2 #(.RST_PRIO(RST_PRIO)) u_rr (
        .clk(clk),
        .reset_n(reset_n),
        .req({bus.d_req, bus.i_req}),
        .accept(accept),
        .grant(grant)
    );

    // handshake and next state: a new request is taken whenever no access is on the bus
    always_comb begin
        accept      = (state != ACCESS) && (bus.i_req || bus.d_req);
        bus.i_ready = accept && grant == PORT_INSTR;
        bus.d_ready = accept && grant == PORT_DATA;
        state_next  = accept ? ACCESS : (state == ACCESS ? RESP : IDLE);
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_next;
    end

    // memory-side request registers: loaded on accept, strobe low only for the following cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_enable_n    <= 1'b1;
            bus.mem_is_write    <= 1'b0;
            bus.mem_is_unsigned <= 1'b0;
            bus.mem_op_size     <= '0;
            bus.mem_addr        <= '0;
            bus.mem_in          <= '0;
            owner               <= PORT_INSTR;
        end else begin
            bus.mem_enable_n <= !accept;
            if (accept) begin
                owner               <= grant;
                bus.mem_is_write    <= grant == PORT_DATA && bus.d_is_write;
                bus.mem_is_unsigned <= grant == PORT_DATA ? bus.d_is_unsigned : 1'b1;
                bus.mem_op_size     <= grant == PORT_DATA ? bus.d_op_size : MEM_OP_SIZE_WORD;
                bus.mem_addr        <= grant == PORT_DATA ? bus.d_addr : bus.i_addr;
                bus.mem_in          <= grant == PORT_DATA ? bus.d_wdata : '0;
            end
        end
    end

    // response value: only a fault-free read returns memory data
    always_comb begin
        fault = fault_vec(bus.mem_op_fault, bus.mem_addr_fault, bus.mem_access_fault_n);
        rdata = (|fault || bus.mem_is_write) ? '0 : bus.mem_out;
    end

    // capture at the end of RESP into the owning port; valid lasts exactly one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.i_rsp_valid <= 1'b0;
            bus.i_rdata     <= '0;
            bus.i_fault     <= '0;
            bus.d_rsp_valid <= 1'b0;
            bus.d_rdata     <= '0;
            bus.d_fault     <= '0;
        end else begin
            bus.i_rsp_valid <= state == RESP && owner == PORT_INSTR;
            bus.d_rsp_valid <= state == RESP && owner == PORT_DATA;
            if (state == RESP && owner == PORT_INSTR) begin
                bus.i_rdata <= rdata;
                bus.i_fault <= fault;
            end
            if (state == RESP && owner == PORT_DATA) begin
                bus.d_rdata <= rdata;
                bus.d_fault <= fault;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a transaction-level arbiter model and random traffic
module tb_mem_arbiter;
    import mem_pkg::*;
    localparam logic RST_PRIO = 1'b1;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic [2:0]  fault;
        int          due;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    mem_arbiter_if bus();
    mem_arbiter #(.RST_PRIO(RST_PRIO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    rsp_t sb[$];
    logic acc_log_port[$];
    int   acc_log_cyc[$];
    logic last_port;
    logic prev_acc;
    logic [31:0] exp_addr, exp_in;
    logic exp_wr, exp_uns;
    logic [1:0] exp_size;
    logic rand_mem = 1'b1;
    logic [31:0] m_out = '0;
    logic m_op = 1'b0, m_addrf = 1'b0, m_accn = 1'b1;
    logic [31:0] nx_out;
    logic nx_op, nx_addrf, nx_accn;
    int acc_seq = 0;
    int rsp_cnt[2];
    logic [31:0] last_rdata[2];
    logic [2:0]  last_fault[2];

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc++;

    // reference model: decides who should be accepted and predicts the response
    always @(negedge clk) begin : observer
        logic open, win, acc;
        logic [2:0] fv;
        rsp_t r;
        if (!reset_n) begin
            sb.delete();
            prev_acc  = 1'b0;
            last_port = ~RST_PRIO;
        end else begin
            open = !prev_acc;
            win  = (bus.i_req && bus.d_req) ? ~last_port : bus.d_req;
            acc  = open && (bus.i_req || bus.d_req);
            chk("ready", 64'({bus.i_ready, bus.d_ready}), 64'({acc && !win, acc && win}));
            chk("mem_enable_n", 64'(bus.mem_enable_n), 64'(!prev_acc));
            if (!bus.mem_enable_n) begin
                chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
                chk("mem_ctl_in", 64'({bus.mem_is_write, bus.mem_is_unsigned, bus.mem_op_size, bus.mem_in}),
                    64'({exp_wr, exp_uns, exp_size, exp_in}));
            end
            if (acc) begin
                last_port = win;
                exp_addr  = win ? bus.d_addr : bus.i_addr;
                exp_in    = win ? bus.d_wdata : 32'h0;
                exp_wr    = win ? bus.d_is_write : 1'b0;
                exp_uns   = win ? bus.d_is_unsigned : 1'b1;
                exp_size  = win ? bus.d_op_size : MEM_OP_SIZE_WORD;
                if (rand_mem) begin
                    nx_out   = $urandom;
                    nx_op    = $urandom_range(3) == 0;
                    nx_addrf = $urandom_range(3) == 0;
                    nx_accn  = $urandom_range(3) != 0;
                end else begin
                    nx_out   = m_out;
                    nx_op    = m_op;
                    nx_addrf = m_addrf;
                    nx_accn  = m_accn;
                end
                fv      = {nx_op, nx_addrf, !nx_accn};
                r.port  = win;
                r.fault = fv;
                r.rdata = (fv != 3'b000 || exp_wr) ? 32'h0 : nx_out;
                r.due   = cyc + 3;
                sb.push_back(r);
                acc_log_port.push_back(win);
                acc_log_cyc.push_back(cyc);
                acc_seq++;
            end
            prev_acc = acc;
        end
    end

    // memory stand-in: presents the chosen response right after each accept edge
    initial begin : memory
        int applied;
        applied = 0;
        bus.mem_out = '0;
        bus.mem_op_fault = 1'b0;
        bus.mem_addr_fault = 1'b0;
        bus.mem_access_fault_n = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (applied != acc_seq) begin
                bus.mem_out = nx_out;
                bus.mem_op_fault = nx_op;
                bus.mem_addr_fault = nx_addrf;
                bus.mem_access_fault_n = nx_accn;
                applied = acc_seq;
            end
        end
    end

    // response monitor: pops the scoreboard whenever a port shows rsp_valid
    always @(negedge clk) begin : monitor
        rsp_t r;
        logic [1:0] vp;
        if (reset_n) begin
            vp = {bus.i_rsp_valid, bus.d_rsp_valid};
            if (vp != 2'b00) begin
                if (sb.size() == 0) chk("rsp_unexpected", 64'(vp), 64'(0));
                else begin
                    r = sb.pop_front();
                    chk("rsp_port", 64'(vp), 64'(r.port ? 2'b01 : 2'b10));
                    chk("rsp_cycle", 64'(cyc), 64'(r.due));
                    chk("rsp_rdata", 64'(r.port ? bus.d_rdata : bus.i_rdata), 64'(r.rdata));
                    chk("rsp_fault", 64'(r.port ? bus.d_fault : bus.i_fault), 64'(r.fault));
                    rsp_cnt[r.port]++;
                    last_rdata[r.port] = r.port ? bus.d_rdata : bus.i_rdata;
                    last_fault[r.port] = r.port ? bus.d_fault : bus.i_fault;
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                r = sb.pop_front();
                chk("rsp_missing", 64'(vp), 64'(r.port ? 2'b01 : 2'b10));
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_enable_n", 64'(bus.mem_enable_n), 64'(1));
        chk("rst_mem_bus", 64'({bus.mem_is_write, bus.mem_is_unsigned, bus.mem_op_size, bus.mem_addr}), 64'(0));
        chk("rst_mem_in", 64'(bus.mem_in), 64'(0));
        chk("rst_rsp", 64'({bus.i_rsp_valid, bus.d_rsp_valid, bus.i_fault, bus.d_fault}), 64'(0));
        chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_acc(input logic port);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (port ? (bus.d_req && bus.d_ready) : (bus.i_req && bus.i_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("accept_timeout", 64'(ok), 64'(1));
    endtask

    task automatic issue_d(input logic w, input logic u, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        bus.d_is_write = w;
        bus.d_is_unsigned = u;
        bus.d_op_size = sz;
        bus.d_addr = a;
        bus.d_wdata = wd;
        bus.d_req = 1'b1;
        wait_acc(1'b1);
        bus.d_req = 1'b0;
    endtask

    task automatic issue_i(input logic [31:0] a);
        bus.i_addr = a;
        bus.i_req = 1'b1;
        wait_acc(1'b0);
        bus.i_req = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("drain", 64'(sb.size()), 64'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        int base, cnt;
        logic it, dt;
        bus.i_req = 1'b0;
        bus.i_addr = '0;
        bus.d_req = 1'b0;
        bus.d_is_write = 1'b0;
        bus.d_is_unsigned = 1'b0;
        bus.d_op_size = MEM_OP_SIZE_WORD;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        rsp_cnt[0] = 0;
        rsp_cnt[1] = 0;
        do_reset();

        rand_mem = 1'b0;
        m_out = 32'hDEADBEEF;
        issue_d(1'b0, 1'b0, MEM_OP_SIZE_WORD, 32'h20000010, 32'h0);
        drain();
        chk("t030_rdata", 64'(last_rdata[1]), 64'(32'hDEADBEEF));
        chk("t030_fault", 64'(last_fault[1]), 64'(0));
        chk("t030_count", 64'(rsp_cnt[1]), 64'(1));

        do_reset();
        rand_mem = 1'b1;
        base = acc_log_port.size();
        bus.i_addr = 32'h00001000;
        bus.d_addr = 32'h20000100;
        bus.d_is_write = 1'b0;
        bus.d_op_size = MEM_OP_SIZE_WORD;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        for (int k = 0; k < 40 && acc_log_port.size() < base + 6; k++) begin
            @(posedge clk);
            #1;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        chk("t031_count", 64'(acc_log_port.size() - base), 64'(6));
        for (int k = 0; k < 6 && base + k < acc_log_port.size(); k++) begin
            chk("t031_port", 64'(acc_log_port[base + k]), 64'(k % 2 == 0));
            if (k > 0) chk("t031_gap", 64'(acc_log_cyc[base + k] - acc_log_cyc[base + k - 1]), 64'(2));
        end
        drain();

        rand_mem = 1'b0;
        m_out = 32'hCAFEF00D;
        m_addrf = 1'b1;
        issue_d(1'b1, 1'b0, MEM_OP_SIZE_WORD, 32'h20000002, 32'h12345678);
        drain();
        chk("t032_fault", 64'(last_fault[1]), 64'(3'b010));
        chk("t032_rdata", 64'(last_rdata[1]), 64'(0));

        m_addrf = 1'b0;
        m_accn = 1'b0;
        m_out = 32'h13579BDF;
        cnt = rsp_cnt[1];
        issue_i(32'h40000000);
        drain();
        chk("t033_fault", 64'(last_fault[0]), 64'(3'b001));
        chk("t033_rdata", 64'(last_rdata[0]), 64'(0));
        chk("t033_no_d_rsp", 64'(rsp_cnt[1]), 64'(cnt));

        m_accn = 1'b1;
        m_op = 1'b1;
        issue_d(1'b0, 1'b1, 2'b11, 32'h20000020, 32'h0);
        drain();
        chk("t035_fault", 64'(last_fault[1]), 64'(3'b100));
        chk("t035_rdata", 64'(last_rdata[1]), 64'(0));

        m_op = 1'b0;
        m_out = 32'h55AA55AA;
        cnt = rsp_cnt[1];
        bus.d_is_write = 1'b0;
        bus.d_op_size = MEM_OP_SIZE_WORD;
        bus.d_addr = 32'h20000030;
        bus.d_req = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.mem_enable_n) break;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("t034_enable_n", 64'(bus.mem_enable_n), 64'(1));
        chk("t034_rsp_valid", 64'({bus.i_rsp_valid, bus.d_rsp_valid}), 64'(0));
        bus.d_req = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t034_discarded", 64'(rsp_cnt[1]), 64'(cnt));
        m_out = 32'h0BADCAFE;
        issue_d(1'b0, 1'b0, MEM_OP_SIZE_WORD, 32'h20000040, 32'h0);
        drain();
        chk("t034_after_rdata", 64'(last_rdata[1]), 64'(32'h0BADCAFE));
        chk("t034_after_count", 64'(rsp_cnt[1]), 64'(cnt + 1));

        rand_mem = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            it = bus.i_req && bus.i_ready;
            dt = bus.d_req && bus.d_ready;
            @(posedge clk);
            #1;
            if (!bus.i_req || it) begin
                bus.i_req = $urandom_range(2) != 0;
                bus.i_addr = $urandom;
            end
            if (!bus.d_req || dt) begin
                bus.d_req = $urandom_range(2) != 0;
                bus.d_is_write = $urandom_range(1) == 1;
                bus.d_is_unsigned = $urandom_range(1) == 1;
                bus.d_op_size = 2'($urandom_range(3));
                bus.d_addr = $urandom;
                bus.d_wdata = $urandom;
            end
        end
        for (int k = 0; k < 20 && (bus.i_req || bus.d_req); k++) begin
            @(negedge clk);
            it = bus.i_req && bus.i_ready;
            dt = bus.d_req && bus.d_ready;
            @(posedge clk);
            #1;
            if (it) bus.i_req = 1'b0;
            if (dt) bus.d_req = 1'b0;
        end
        chk("final_idle", 64'({bus.i_req, bus.d_req}), 64'(0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
